md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and models the MDU latency with a busy counter.
- Raises a stall to the hazard logic while any MDU-using instruction sits in D during an operation.
- Results commit to HI/LO only when the operation completes. HI/LO read values (mfhi/mflo) are exported to E-stage forwarding muxes.

---
 rtl/md_sched_pkg.sv | 25 ++
 rtl/md_sched_arith.sv | 75 +++++++
 rtl/md_sched.sv | 113 +++++++++++
 tb/tb_md_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_sched_pkg                                                  |
// | Purpose  : Shared definitions for the multiply/divide scheduler: MDU     |
// |            opcode encoding and default operation latencies.              |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage
`default_nettype wire

// File: rtl/md_sched_arith.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_arith                                                      |
// | Purpose  : Combinational MDU datapath. Produces the 64-bit {hi,lo}       |
// |            result for mult/multu/div/divu and flags divide-by-zero.      |
// | Ports    : op     in  3   MDU opcode                                     |
// |            a      in  32  rs operand (dividend / multiplicand)           |
// |            b      in  32  rt operand (divisor / multiplier)              |
// |            result out 64  {hi,lo}; div: hi=remainder, lo=quotient        |
// |            div0   out 1   divide op with b == 0                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module md_arith
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Signed ops are done on magnitudes and the sign is re-applied afterwards.
  // This makes 0x80000000 / -1 fall out naturally as 0x80000000 (the
  // magnitude 2^31 fits in 32 unsigned bits) with no overflow special case.
  always_comb begin
    w_is_mul  = (op == MD_MULT) || (op == MD_MULTU);
    w_is_div  = (op == MD_DIV)  || (op == MD_DIVU);
    w_signed  = (op == MD_MULT) || (op == MD_DIV);
    w_a_neg   = w_signed & a[31];
    w_b_neg   = w_signed & b[31];
    w_a_mag   = w_a_neg ? (32'd0 - a) : a;
    w_b_mag   = w_b_neg ? (32'd0 - b) : b;
    // Substitute a harmless divisor on zero; the result is discarded anyway.
    w_divisor = (b == 32'd0) ? 32'd1 : w_b_mag;

    w_prod = {32'd0, w_a_mag} * {32'd0, w_b_mag};
    if (w_a_neg ^ w_b_neg) begin
      w_prod = 64'd0 - w_prod;
    end

    w_quo = w_a_mag / w_divisor;
    w_rem = w_a_mag % w_divisor;
    if (w_a_neg ^ w_b_neg) begin
      w_quo = 32'd0 - w_quo;
    end
    // Remainder takes the sign of the dividend.
    if (w_a_neg) begin
      w_rem = 32'd0 - w_rem;
    end

    result = 64'd0;
    if (w_is_mul) begin
      result = w_prod;
    end else if (w_is_div) begin
      result = {w_rem, w_quo};
    end

    div0 = w_is_div && (b == 32'd0);
  end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_sched                                                      |
// | Purpose  : Multi-cycle multiply/divide scheduler. Owns HI/LO, models     |
// |            MDU latency with a busy counter and requests pipeline stalls. |
// | Ports    : clk, reset          clock, synchronous active-high reset      |
// |            E_valid            E stage holds a real instruction           |
// |            E_md_op [2:0]      MDU opcode                                 |
// |            E_rs, E_rt [31:0]  forwarded operands                         |
// |            D_is_md            D-stage instruction uses the MDU           |
// |            start              operation launched this cycle (comb)       |
// |            busy               counter nonzero (register-derived)         |
// |            md_stall           stall request to the hazard unit (comb)    |
// |            hi, lo [31:0]      current HI / LO registers                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_is_md,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  logic             r_pend_div0;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_div0;
  logic             w_is_launch_op;
  logic             w_is_div_op;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_commit;

  md_arith u_arith (
    .op     (E_md_op),
    .a      (E_rs),
    .b      (E_rt),
    .result (w_result),
    .div0   (w_div0)
  );

  always_comb begin
    w_is_div_op    = (E_md_op == MD_DIV) || (E_md_op == MD_DIVU);
    w_is_launch_op = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU) || w_is_div_op;
    busy           = (r_cnt != '0);
    start          = E_valid && w_is_launch_op && !busy;
    w_mthi         = E_valid && (E_md_op == MD_MTHI) && !busy;
    w_mtlo         = E_valid && (E_md_op == MD_MTLO) && !busy;
    // The last busy cycle is the one whose closing edge takes the count to 0.
    w_commit       = (r_cnt == C_CNT_ONE);
    md_stall       = D_is_md && (start || busy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_pend      <= 64'd0;
      r_pend_div0 <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
    end else begin
      if (start) begin
        r_cnt       <= w_is_div_op ? C_DIV_CNT : C_MULT_CNT;
        r_pend      <= w_result;
        r_pend_div0 <= w_div0;
      end else if (busy) begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end

      // Commit and mthi/mtlo are mutually exclusive: the moves need ~busy.
      if (w_commit) begin
        if (!r_pend_div0) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end else begin
        if (w_mthi) begin
          r_hi <= E_rs;
        end
        if (w_mtlo) begin
          r_lo <= E_rs;
        end
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_md_sched                                                   |
// | Purpose  : Directed self-checking bench for md_sched.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk;
  logic        reset;
  logic        E_valid;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_is_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;

  // Bench-side expected HI/LO, updated with hand-computed values.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .E_valid  (E_valid),
    .E_md_op  (E_md_op),
    .E_rs     (E_rs),
    .E_rt     (E_rt),
    .D_is_md  (D_is_md),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Launch one operation, then follow it through n busy cycles to commit.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic dmd);
    E_valid = 1'b1;
    E_md_op = op;
    E_rs    = rs;
    E_rt    = rt;
    D_is_md = dmd;
    #1;
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    chk({tag, "_stall_launch"}, {31'd0, md_stall}, {31'd0, dmd});
    tick();
    E_valid = 1'b0;
    E_md_op = MD_NONE;
    #1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_hi_hold%0d", tag, i), hi, m_hi);
      chk($sformatf("%s_lo_hold%0d", tag, i), lo, m_lo);
      chk($sformatf("%s_stall%0d", tag, i), {31'd0, md_stall}, {31'd0, dmd});
      tick();
    end
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_stall_end"}, {31'd0, md_stall}, 32'd0);
    D_is_md = 1'b0;
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic move(input string tag, input logic [2:0] op, input logic [31:0] rs);
    E_valid = 1'b1;
    E_md_op = op;
    E_rs    = rs;
    E_rt    = 32'd0;
    #1;
    chk({tag, "_no_start"}, {31'd0, start}, 32'd0);
    tick();
    E_valid = 1'b0;
    E_md_op = MD_NONE;
    #1;
    if (op == MD_MTHI) m_hi = rs;
    else m_lo = rs;
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    reset   = 1'b1;
    E_valid = 1'b0;
    E_md_op = MD_NONE;
    E_rs    = 32'd0;
    E_rt    = 32'd0;
    D_is_md = 1'b0;
    tick();
    tick();
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Bubble carrying a mult opcode must not launch.
    E_valid = 1'b0;
    E_md_op = MD_MULT;
    E_rs    = 32'd7;
    E_rt    = 32'd9;
    #1;
    chk("bubble_start", {31'd0, start}, 32'd0);
    tick();
    chk("bubble_busy", {31'd0, busy}, 32'd0);
    chk("bubble_lo", lo, 32'd0);
    E_md_op = MD_NONE;

    // -2 * 3 = -6 ; D_is_md=0 so no stall at any point.
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    // 0xFFFFFFFE * 3 = 0x2_FFFFFFFA ; D_is_md held -> stall launch + 5 busy.
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1);
    // -7 / 2 = -3 rem -1
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    // Most-negative / -1 : quotient wraps to itself, remainder 0.
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b1);
    // 0xFFFFFFFF / 16 unsigned = 0x0FFFFFFF rem 0xF
    run_op("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

    move("mthi11", MD_MTHI, 32'h0000_0011);
    move("mtlo22", MD_MTLO, 32'h0000_0022);
    // Divide by zero: full latency, HI/LO left untouched.
    run_op("divu0", MD_DIVU, 32'd5, 32'd0, 10, 32'h0000_0011, 32'h0000_0022, 1'b0);
    run_op("div0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 10, 32'h0000_0011, 32'h0000_0022, 1'b1);

    move("mthiABCD", MD_MTHI, 32'h0000_ABCD);

    // Reset on the third busy cycle of a divide aborts it.
    E_valid = 1'b1;
    E_md_op = MD_DIV;
    E_rs    = 32'd100;
    E_rt    = 32'd7;
    tick();
    E_valid = 1'b0;
    E_md_op = MD_NONE;
    tick();
    tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_commit_hi", hi, 32'd0);
    chk("abort_no_commit_lo", lo, 32'd0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
